// File: rtl/propose_integer_continuous_sequencer.sv
// Control sequencer for the integer/continuous propose datapath: optional clause
// reload from memory, reduce enable, comparator settle, segment select and capture.
module propose_integer_continuous_sequencer #(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
    parameter int SELECT_LATENCY                      = 2
) (
    input  logic                                   in_clk,
    input  logic                                   in_reset,
    input  logic                                   in_start,
    input  logic                                   in_reload,
    input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_num_clauses,
    input  logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] in_variable_index,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_read_address,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_clause_read_data,
    output logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_clause_coefficients,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_clause_index,
    output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] out_variable_index,
    output logic [2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_reduce_enable,
    output logic                                   out_select_enable,
    input  logic [1:0]                             in_segment_type,
    input  logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_segment_from,
    input  logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_segment_to,
    input  logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   in_segment_weight,
    output logic [1:0]                             out_segment_type,
    output logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_segment_from,
    output logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_segment_to,
    output logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   out_segment_weight,
    output logic                                   out_busy,
    output logic                                   out_done
);

    localparam int W   = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int VI  = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
    localparam int K   = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int NC  = 2**K;
    localparam int WCW = (SELECT_LATENCY > 1) ? $clog2(SELECT_LATENCY) : 1;
    localparam logic [K:0]     NC_V      = (K+1)'(NC);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SELECT_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REDUCE,
        ST_SETTLE,
        ST_SELECT,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [K:0]     k_cnt;
    logic [K:0]     n_reg;
    logic [WCW-1:0] wait_cnt;
    logic [VI-1:0]  var_q;
    logic [K:0]     num_clamped;

    assign num_clamped = (in_num_clauses > NC_V) ? NC_V : in_num_clauses;

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (in_start) next_state = in_reload ? ST_LOAD : ST_REDUCE;
            ST_LOAD:   if (k_cnt == n_reg) next_state = ST_REDUCE;
            ST_REDUCE: next_state = ST_SETTLE;
            ST_SETTLE: next_state = ST_SELECT;
            ST_SELECT: next_state = ST_WAIT;
            ST_WAIT:   if (wait_cnt == WAIT_LAST) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Counters, latched start parameters and the segment capture register.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            k_cnt              <= '0;
            n_reg              <= '0;
            wait_cnt           <= '0;
            var_q              <= '0;
            out_segment_type   <= '0;
            out_segment_from   <= '0;
            out_segment_to     <= '0;
            out_segment_weight <= '0;
        end else begin
            if (state == ST_IDLE && in_start) begin
                var_q <= in_variable_index;
                n_reg <= num_clamped;
                k_cnt <= '0;
            end
            if (state == ST_LOAD) begin
                k_cnt <= (k_cnt == n_reg) ? '0 : k_cnt + (K+1)'(1);
            end
            if (state == ST_WAIT) begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt           <= '0;
                    out_segment_type   <= in_segment_type;
                    out_segment_from   <= in_segment_from;
                    out_segment_to     <= in_segment_to;
                    out_segment_weight <= in_segment_weight;
                end else begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
            end
        end
    end

    // Memory returns data one cycle after the address, so the write select lags by one.
    always_comb begin
        out_clause_read_address = '0;
        out_clause_index        = NC_V;
        out_reduce_enable       = '0;
        if (state == ST_LOAD) begin
            if (k_cnt < n_reg) out_clause_read_address = k_cnt[K-1:0];
            if (k_cnt != '0)   out_clause_index        = k_cnt - (K+1)'(1);
        end
        if (state == ST_REDUCE) begin
            for (int i = 0; i < NC; i++) begin
                out_reduce_enable[i] = (n_reg > (K+1)'(i));
            end
        end
    end

    assign out_clause_coefficients = in_clause_read_data;
    assign out_variable_index      = var_q;
    assign out_select_enable       = (state == ST_SELECT);
    assign out_busy                = (state != ST_IDLE);
    assign out_done                = (state == ST_DONE);

endmodule

// File: doc/propose_integer_continuous_sequencer.md
# propose_integer_continuous_sequencer

Sequencer for the integer/continuous propose datapath: clause registers, reduce blocks, C1/C2 comparator trees and the segment selector. On each start request it optionally loads clause coefficients from an external clause memory. It then enables the reduce blocks, lets the comparator trees settle and triggers segment selection. Finally it captures the chosen segment and reports done to the top-level MCMC control unit.

## Interface
Parameters:
- MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, 8, coefficient/bias width (W)
- MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, 2, variable index width; 2**this variables
- MAX_BIT_WIDTH_OF_CLAUSES_INDEX, 3, clause index width (K); NC = 2**K clause slots
- SELECT_LATENCY, 2, cycles from select-enable to valid segment outputs (≥1)

Ports:
- in_clk  in  1  clock
- in_reset  in  1  reset; asynchronous, active-high
- in_start  in  1  start request; sampled only in IDLE
- in_reload  in  1  sampled with in_start: 1 = load clauses from memory first
- in_num_clauses  in  K+1  active clause count, 0..NC; values > NC clamp to NC
- in_variable_index  in  VI  variable to move; latched at start
- out_clause_read_address  out  K  clause memory address; memory has 1-cycle read latency
- in_clause_read_data  in  (2**VI+1)*W  coefficients returned by memory
- out_clause_coefficients  out  (2**VI+1)*W  combinational pass-through of in_clause_read_data
- out_clause_index  out  K+1  clause register write select; NC (MSB set) = no write
- out_variable_index  out  VI  latched variable index to reduce blocks
- out_reduce_enable  out  NC  per-clause reduce enable
- out_select_enable  out  1  one-cycle trigger to segment selector
- in_segment_type  in  2  selector result type
- in_segment_from  in  W  selector result lower bound, signed
- in_segment_to  in  W  selector result upper bound, signed
- in_segment_weight  in  W+1  selector result weight, unsigned
- out_segment_type  out  2  captured result type
- out_segment_from  out  W  captured lower bound
- out_segment_to  out  W  captured upper bound
- out_segment_weight  out  W+1  captured weight
- out_busy  out  1  high in every state except IDLE
- out_done  out  1  one-cycle pulse; captured outputs valid

## Operation
- States: IDLE, LOAD, REDUCE, SETTLE, SELECT, WAIT, DONE.
- IDLE → LOAD when in_start && in_reload. IDLE → REDUCE when in_start && !in_reload.
  - On that edge, latch in_variable_index and N = min(in_num_clauses, NC).
- LOAD: counter k runs 0..N, one cycle per value.
  - Address output: out_clause_read_address = k while k<N, else 0.
  - Write select: out_clause_index = k−1 for k≥1; NC at k=0.
  - Transition: → REDUCE after k=N. With N=0, LOAD lasts one cycle and writes nothing.
- REDUCE (1 cycle): out_reduce_enable[i] = 1 for i<N, 0 otherwise.
- SETTLE (1 cycle): comparator trees settle; all enables low.
- SELECT (1 cycle): out_select_enable = 1.
- WAIT: SELECT_LATENCY cycles. On the last WAIT edge, register in_segment_* into out_segment_*, then → DONE.
- DONE (1 cycle): out_done = 1, then → IDLE. Captured outputs hold until the next capture.
- in_start is ignored while busy. A start arriving in the DONE cycle is ignored; it is accepted from the next IDLE cycle.
- Clause registers not rewritten keep their previous contents. Clauses with index ≥ N are never enabled, so the selector sees them as inactive.

## Timing
- Reset (async, any state) forces IDLE. Reset values:
  - out_clause_index = NC.
  - All other outputs = 0: enables, address, busy, done, segment outputs, latched variable index.
  - Counters cleared.
- Reset mid-LOAD aborts the load; partially written clause registers are not repaired by this block.
- Latency, start sampled at edge 0:
  - No reload: REDUCE in cycle 1, SELECT in cycle 3, out_done in cycle 4+SELECT_LATENCY.
  - Reload: every stage shifts by N+1 cycles, so out_done is in cycle N+5+SELECT_LATENCY.
- At most one clause register write per cycle. Outside LOAD, out_clause_index is always NC.
- out_reduce_enable and out_select_enable are never high in the same cycle.

## Test plan
- Reset then idle, no start, 10 cycles → out_clause_index=8, all enables/busy/done 0, segment outputs 0.
- Reload start with N=8, memory word = address-tagged pattern → indices 0..7 written in cycles 2..9, each with matching data. out_reduce_enable=8'hFF in cycle 10, out_select_enable in cycle 12, out_done in cycle 15.
- No-reload start with N=3, selector returns type=3/from=−5/to=20/weight=26 → enables=8'h07 in cycle 1; done in cycle 6 with those exact captured values.
- N=0 with reload → one LOAD cycle, no writes (index stays 8), reduce enables 0, select still fires, done in cycle 7.
- in_num_clauses=12 → clamped to 8. A second in_start while busy and one in the DONE cycle are both ignored; a start in the following cycle is accepted.
- Assert reset during LOAD at k=4 → next cycle IDLE, busy 0, index 8. A fresh start then completes normally.
